// File: rtl/acce_wb_pkg.sv
// Shared types and constants for the accelerator write-back DMA.
// Holds the FSM encoding, ICB constants and the word address helper.
package acce_wb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [3:0]  ICB_WMASK_FULL = 4'hF;
   localparam int unsigned WORD_BYTES     = 4;

   // Byte address of word idx in the run; wraps modulo 2^32 by construction.
   function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
      return base + idx * WORD_BYTES;
   endfunction

endpackage

// File: rtl/acce_wb_fifo.sv
// Synchronous FIFO, DEPTH x W, with full/empty flags and a registered-array head.
// A word written in cycle N becomes visible on o_head from cycle N+1.
module acce_wb_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned W     = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_push,
   input  logic [W-1:0] i_wdata,
   input  logic         i_pop,
   output logic [W-1:0] o_head,
   output logic         o_full,
   output logic         o_empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [W-1:0] r_mem [DEPTH];
   logic [AW:0]  r_wr_ptr;
   logic [AW:0]  r_rd_ptr;
   logic         w_do_push;
   logic         w_do_pop;

   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;

   // NOTE: storage has no reset; only the pointers define which entries are valid.
   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
   end

   assign o_head  = r_mem[r_rd_ptr[AW-1:0]];
   assign o_empty = (r_wr_ptr == r_rd_ptr);
   assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

endmodule

// File: rtl/acce_wb_dma.sv
// Write-back DMA: buffers accelerator results and drains them as ICB writes,
// pulsing done only after every issued write has been acknowledged.
module acce_wb_dma
   import acce_wb_pkg::*;
#(
   parameter int unsigned DEPTH    = 8,
   parameter int unsigned MAX_OUTS = 4,
   parameter int unsigned CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [31:0]      base_addr,
   input  logic [CNT_W-1:0] result_num,
   input  logic [31:0]      data_i,
   input  logic             valid_i,
   output logic             ready_o,
   output logic             m_icb_cmd_valid,
   input  logic             m_icb_cmd_ready,
   output logic [31:0]      m_icb_cmd_addr,
   output logic             m_icb_cmd_read,
   output logic [31:0]      m_icb_cmd_wdata,
   output logic [3:0]       m_icb_cmd_wmask,
   input  logic             m_icb_rsp_valid,
   output logic             m_icb_rsp_ready,
   input  logic [31:0]      m_icb_rsp_rdata,
   input  logic             m_icb_rsp_err,
   output logic             busy,
   output logic             done,
   output logic             err
);

   localparam int unsigned       OUTS_W     = $clog2(MAX_OUTS + 1);
   localparam logic [OUTS_W-1:0] MAX_OUTS_C = OUTS_W'(MAX_OUTS);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [31:0]       r_base_addr;
   logic [CNT_W-1:0]  r_num;
   logic [CNT_W-1:0]  r_pushed;
   logic [CNT_W-1:0]  r_issued;
   logic [OUTS_W-1:0] r_outs;
   logic              r_err;

   logic              w_start_go;
   logic              w_push;
   logic              w_pop;
   logic              w_rsp_take;
   logic              w_cmd_valid;
   logic              w_full;
   logic              w_empty;
   logic [31:0]       w_head;
   logic              w_unused;

   assign w_unused   = &{1'b0, m_icb_rsp_rdata};
   assign w_start_go = start && (r_state == ST_IDLE);
   assign w_push     = valid_i && ready_o;
   assign w_pop      = w_cmd_valid && m_icb_cmd_ready;
   // A response with nothing outstanding is spurious and must not underflow the counter.
   assign w_rsp_take = m_icb_rsp_valid && (r_outs != '0);

   acce_wb_fifo #(.DEPTH(DEPTH), .W(32)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_wdata (data_i),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      // NOTE: default assignment first so no path leaves the signal unassigned (no latch).
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (start) w_state_nxt = ST_RUN;
         ST_RUN:  if ((r_issued == r_num) && (r_outs == '0)) w_state_nxt = ST_DONE;
         ST_DONE: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      busy        = 1'b0;
      done        = 1'b0;
      ready_o     = 1'b0;
      w_cmd_valid = 1'b0;
      case (r_state)
         ST_RUN: begin
            busy        = 1'b1;
            ready_o     = !w_full && (r_pushed < r_num);
            w_cmd_valid = !w_empty && (r_outs < MAX_OUTS_C);
         end
         ST_DONE: done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_base_addr <= '0;
         r_num       <= '0;
         r_pushed    <= '0;
         r_issued    <= '0;
         r_outs      <= '0;
         r_err       <= 1'b0;
      end else if (w_start_go) begin
         r_base_addr <= base_addr;
         r_num       <= result_num;
         r_pushed    <= '0;
         r_issued    <= '0;
         r_outs      <= '0;
         r_err       <= 1'b0;
      end else begin
         if (w_push) r_pushed <= r_pushed + CNT_W'(1);
         if (w_pop)  r_issued <= r_issued + CNT_W'(1);
         case ({w_pop, w_rsp_take})
            2'b10:   r_outs <= r_outs + OUTS_W'(1);
            2'b01:   r_outs <= r_outs - OUTS_W'(1);
            default: ;
         endcase
         if (w_rsp_take && m_icb_rsp_err) r_err <= 1'b1;
      end
   end

   // Address and data are zero whenever no command is offered, including out of reset.
   assign m_icb_cmd_valid = w_cmd_valid;
   assign m_icb_cmd_addr  = w_cmd_valid ? word_addr(r_base_addr, 32'(r_issued)) : '0;
   assign m_icb_cmd_wdata = w_cmd_valid ? w_head : '0;
   assign m_icb_cmd_read  = 1'b0;
   assign m_icb_cmd_wmask = ICB_WMASK_FULL;
   assign m_icb_rsp_ready = 1'b1;
   assign err             = r_err;

endmodule

// File: tb/tb_acce_wb_dma.sv
// Directed self-checking bench for acce_wb_dma with a responder/command logger
// running on the falling edge.
module tb_acce_wb_dma;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [31:0] base_addr = '0;
   logic [15:0] result_num = '0;
   logic [31:0] data_i = '0;
   logic        valid_i = 1'b0;
   logic        ready_o;
   logic        m_icb_cmd_valid;
   logic        m_icb_cmd_ready = 1'b0;
   logic [31:0] m_icb_cmd_addr;
   logic        m_icb_cmd_read;
   logic [31:0] m_icb_cmd_wdata;
   logic [3:0]  m_icb_cmd_wmask;
   logic        m_icb_rsp_valid = 1'b0;
   logic        m_icb_rsp_ready;
   logic [31:0] m_icb_rsp_rdata = 32'hDEAD_BEEF;
   logic        m_icb_rsp_err = 1'b0;
   logic        busy;
   logic        done;
   logic        err;

   int n_assert = 0;
   int n_fail   = 0;

   // Responder / logger state
   int          budget   = 0;
   int          pend     = 0;
   int          rsp_cnt  = 0;
   int          err_at   = -1;
   int          done_cnt = 0;
   logic [31:0] log_addr [$];
   logic [31:0] log_data [$];
   logic [4:0]  log_ctl  [$];

   acce_wb_dma #(.DEPTH(8), .MAX_OUTS(4), .CNT_W(16)) dut (
      .clk             (clk),
      .rst             (rst),
      .start           (start),
      .base_addr       (base_addr),
      .result_num      (result_num),
      .data_i          (data_i),
      .valid_i         (valid_i),
      .ready_o         (ready_o),
      .m_icb_cmd_valid (m_icb_cmd_valid),
      .m_icb_cmd_ready (m_icb_cmd_ready),
      .m_icb_cmd_addr  (m_icb_cmd_addr),
      .m_icb_cmd_read  (m_icb_cmd_read),
      .m_icb_cmd_wdata (m_icb_cmd_wdata),
      .m_icb_cmd_wmask (m_icb_cmd_wmask),
      .m_icb_rsp_valid (m_icb_rsp_valid),
      .m_icb_rsp_ready (m_icb_rsp_ready),
      .m_icb_rsp_rdata (m_icb_rsp_rdata),
      .m_icb_rsp_err   (m_icb_rsp_err),
      .busy            (busy),
      .done            (done),
      .err             (err)
   );

   always #5 clk = ~clk;

   // Falling edge: log command handshakes, count done pulses, answer one cycle after a fire.
   always @(negedge clk) begin
      if (rst) begin
         pend            = 0;
         m_icb_rsp_valid = 1'b0;
         m_icb_rsp_err   = 1'b0;
      end else begin
         if (done) done_cnt++;
         if ((budget > 0) && (pend > 0)) begin
            pend--;
            budget--;
            rsp_cnt++;
            m_icb_rsp_valid = 1'b1;
            m_icb_rsp_err   = (rsp_cnt == err_at);
         end else begin
            m_icb_rsp_valid = 1'b0;
            m_icb_rsp_err   = 1'b0;
         end
         if (m_icb_cmd_valid && m_icb_cmd_ready) begin
            pend++;
            log_addr.push_back(m_icb_cmd_addr);
            log_data.push_back(m_icb_cmd_wdata);
            log_ctl.push_back({m_icb_cmd_read, m_icb_cmd_wmask});
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic clear_log();
      log_addr.delete();
      log_data.delete();
      log_ctl.delete();
   endtask

   task automatic do_start(input logic [31:0] base, input logic [15:0] num);
      base_addr  = base;
      result_num = num;
      start      = 1'b1;
      tick();
      start      = 1'b0;
   endtask

   task automatic push_word(input logic [31:0] d);
      int t;
      t       = 0;
      data_i  = d;
      valid_i = 1'b1;
      while (!ready_o && t < 300) begin
         tick();
         t++;
      end
      if (t >= 300) check("push_timeout", 32'(t), 32'd0);
      tick();
      valid_i = 1'b0;
   endtask

   task automatic wait_done(input int target, input int limit);
      int t;
      t = 0;
      while (done_cnt < target && t < limit) begin
         tick();
         t++;
      end
      check("done_count", 32'(done_cnt), 32'(target));
   endtask

   task automatic check_entry(input string tag, input int idx, input logic [31:0] a, input logic [31:0] d);
      if (idx < log_addr.size()) begin
         check({tag, "_addr"}, log_addr[idx], a);
         check({tag, "_data"}, log_data[idx], d);
         check({tag, "_ctl"}, {27'd0, log_ctl[idx]}, 32'h0000_000F);
      end else begin
         check({tag, "_missing"}, 32'(log_addr.size()), 32'(idx + 1));
      end
   endtask

   initial begin
      // Reset values while rst is held
      repeat (2) tick();
      check("rst_ready", ready_o, 1'b0);
      check("rst_cmd_valid", m_icb_cmd_valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_err", err, 1'b0);
      check("rst_addr", m_icb_cmd_addr, 32'h0);
      check("rst_wdata", m_icb_cmd_wdata, 32'h0);
      check("rst_read", m_icb_cmd_read, 1'b0);
      check("rst_wmask", m_icb_cmd_wmask, 4'hF);
      check("rst_rsp_ready", m_icb_rsp_ready, 1'b1);
      rst = 1'b0;
      tick();
      check("idle_ready", ready_o, 1'b0);

      // Basic: 4 words, immediate cmd_ready, responses one cycle later
      m_icb_cmd_ready = 1'b1;
      budget = 1000;
      clear_log();
      do_start(32'h2000_0000, 16'd4);
      check("basic_busy", busy, 1'b1);
      check("basic_ready", ready_o, 1'b1);
      for (int i = 0; i < 4; i++) push_word(32'h0000_00A0 + 32'(i));
      wait_done(1, 100);
      check("basic_done_low", done, 1'b0);
      check("basic_idle", busy, 1'b0);
      check("basic_nwrites", 32'(log_addr.size()), 32'd4);
      for (int i = 0; i < 4; i++)
         check_entry($sformatf("basic_w%0d", i), i, 32'h2000_0000 + 32'(4 * i), 32'h0000_00A0 + 32'(i));
      repeat (5) tick();
      check("basic_done_once", 32'(done_cnt), 32'd1);

      // Backpressure: cmd_ready low while 12 words arrive into an 8-deep FIFO
      m_icb_cmd_ready = 1'b0;
      clear_log();
      do_start(32'h1000_0000, 16'd12);
      for (int i = 0; i < 8; i++) push_word(32'hB000_0000 + 32'(i));
      check("bp_full_ready", ready_o, 1'b0);
      check("bp_cmd_valid", m_icb_cmd_valid, 1'b1);
      check("bp_addr0", m_icb_cmd_addr, 32'h1000_0000);
      check("bp_wdata0", m_icb_cmd_wdata, 32'hB000_0000);
      data_i  = 32'hB000_0008;
      valid_i = 1'b1;
      repeat (20) tick();
      check("bp_ready_held", ready_o, 1'b0);
      check("bp_addr_stable", m_icb_cmd_addr, 32'h1000_0000);
      check("bp_wdata_stable", m_icb_cmd_wdata, 32'hB000_0000);
      check("bp_no_writes", 32'(log_addr.size()), 32'd0);
      m_icb_cmd_ready = 1'b1;
      for (int i = 8; i < 12; i++) push_word(32'hB000_0000 + 32'(i));
      wait_done(2, 200);
      check("bp_nwrites", 32'(log_addr.size()), 32'd12);
      for (int i = 0; i < 12; i++)
         check_entry($sformatf("bp_w%0d", i), i, 32'h1000_0000 + 32'(4 * i), 32'hB000_0000 + 32'(i));

      // Outstanding limit: responses withheld, then released two at a time
      budget = 0;
      clear_log();
      do_start(32'h3000_0000, 16'd8);
      for (int i = 0; i < 8; i++) push_word(32'h3300_0000 + 32'(i));
      repeat (10) tick();
      check("outs_limit_writes", 32'(log_addr.size()), 32'd4);
      check("outs_limit_valid", m_icb_cmd_valid, 1'b0);
      check("outs_limit_busy", busy, 1'b1);
      budget = 2;
      repeat (10) tick();
      check("outs_same_cycle_writes", 32'(log_addr.size()), 32'd6);
      check("outs_same_cycle_valid", m_icb_cmd_valid, 1'b0);
      budget = 1000;
      wait_done(3, 100);
      check("outs_nwrites", 32'(log_addr.size()), 32'd8);
      check_entry("outs_w7", 7, 32'h3000_001C, 32'h3300_0007);

      // Address wrap with a bus error on the second response
      clear_log();
      err_at = rsp_cnt + 2;
      do_start(32'hFFFF_FFF8, 16'd3);
      for (int i = 0; i < 3; i++) push_word(32'h0000_00C0 + 32'(i));
      wait_done(4, 100);
      check("wrap_err", err, 1'b1);
      check_entry("wrap_w0", 0, 32'hFFFF_FFF8, 32'h0000_00C0);
      check_entry("wrap_w1", 1, 32'hFFFF_FFFC, 32'h0000_00C1);
      check_entry("wrap_w2", 2, 32'h0000_0000, 32'h0000_00C2);
      repeat (3) tick();
      check("wrap_err_sticky", err, 1'b1);

      // Zero-length run: RUN one cycle, DONE the next, no traffic; start clears err
      clear_log();
      do_start(32'h8000_0000, 16'd0);
      check("zero_busy", busy, 1'b1);
      check("zero_err_cleared", err, 1'b0);
      check("zero_done_early", done, 1'b0);
      check("zero_ready", ready_o, 1'b0);
      tick();
      check("zero_done", done, 1'b1);
      check("zero_not_busy", busy, 1'b0);
      tick();
      check("zero_done_end", done, 1'b0);
      check("zero_no_writes", 32'(log_addr.size()), 32'd0);
      check("zero_done_count", 32'(done_cnt), 32'd5);

      // Start during RUN ignored; a word beyond result_num is refused
      clear_log();
      do_start(32'h4000_0000, 16'd2);
      base_addr  = 32'h5000_0000;
      result_num = 16'd5;
      start      = 1'b1;
      tick();
      start      = 1'b0;
      check("restart_busy", busy, 1'b1);
      push_word(32'h0000_00D0);
      push_word(32'h0000_00D1);
      data_i  = 32'hDEAD_00FF;
      valid_i = 1'b1;
      tick();
      check("extra_ready", ready_o, 1'b0);
      wait_done(6, 100);
      repeat (3) tick();
      valid_i = 1'b0;
      check("restart_nwrites", 32'(log_addr.size()), 32'd2);
      check_entry("restart_w0", 0, 32'h4000_0000, 32'h0000_00D0);
      check_entry("restart_w1", 1, 32'h4000_0004, 32'h0000_00D1);

      // Reset in the middle of a 6-word run
      budget = 0;
      clear_log();
      do_start(32'h6000_0000, 16'd6);
      push_word(32'h0000_00E0);
      push_word(32'h0000_00E1);
      for (int t = 0; t < 20 && log_addr.size() < 2; t++) tick();
      check("mid_writes", 32'(log_addr.size()), 32'd2);
      check_entry("mid_w0", 0, 32'h6000_0000, 32'h0000_00E0);
      rst = 1'b1;
      #1;
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_ready", ready_o, 1'b0);
      check("mid_rst_cmd_valid", m_icb_cmd_valid, 1'b0);
      check("mid_rst_addr", m_icb_cmd_addr, 32'h0);
      check("mid_rst_wdata", m_icb_cmd_wdata, 32'h0);
      check("mid_rst_done", done, 1'b0);
      check("mid_rst_err", err, 1'b0);
      tick();
      tick();
      rst = 1'b0;
      tick();
      check("mid_no_done", 32'(done_cnt), 32'd6);
      budget = 1000;
      clear_log();
      do_start(32'h7000_0000, 16'd1);
      check("post_rst_ready", ready_o, 1'b1);
      push_word(32'h0000_0077);
      wait_done(7, 100);
      check("post_rst_nwrites", 32'(log_addr.size()), 32'd1);
      check_entry("post_rst_w0", 0, 32'h7000_0000, 32'h0000_0077);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
